// File: rtl/vdp_sprite_meta_scheduler.sv
// Queues host metadata writes and replays them onto the sprite core meta port, optionally vblank-gated.
// Push->meta_we latency 2 cycles; host_ready drops when the queue is full and excess writes set overflow.

module vdp_sprite_meta_fifo #(
    parameter int WIDTH     = 26,
    parameter int ADDR_BITS = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 push,
    input  logic [WIDTH-1:0]     push_data,
    input  logic                 pop,
    output logic [WIDTH-1:0]     head,
    output logic [ADDR_BITS:0]   count,
    output logic                 full,
    output logic                 empty
);
    localparam int DEPTH = 1 << ADDR_BITS;

    logic [WIDTH-1:0]     mem [DEPTH];
    logic [ADDR_BITS-1:0] wr_ptr;
    logic [ADDR_BITS-1:0] rd_ptr;

    assign head  = mem[rd_ptr];
    assign full  = (count == (ADDR_BITS+1)'(DEPTH));
    assign empty = (count == '0);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

module vdp_sprite_meta_scheduler #(
    parameter int         FIFO_DEPTH_BITS = 4,
    parameter logic [8:0] HIDDEN_Y        = 9'h1F0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     host_write_en,
    input  logic [9:0]               host_address,
    input  logic [15:0]              host_write_data,
    output logic                     host_ready,
    input  logic                     commit_mode,
    input  logic                     vblank,
    output logic [7:0]               meta_address,
    output logic [15:0]              meta_write_data,
    output logic [2:0]               meta_block_select,
    output logic                     meta_we,
    output logic                     busy,
    output logic [FIFO_DEPTH_BITS:0] fifo_level,
    output logic                     overflow
);
    typedef struct packed {
        logic [1:0]  blk;
        logic [7:0]  idx;
        logic [15:0] dat;
    } entry_t;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t  state;
    logic [7:0] clr_idx;
    logic    gate;
    logic    push;
    logic    pop;
    logic    full;
    logic    empty;
    entry_t  in_entry;
    entry_t  head;

    assign gate       = !commit_mode || vblank;
    assign host_ready = !full;
    assign push       = host_write_en && !full;
    // A pop never bypasses a full queue: host_ready comes from the registered count only.
    assign pop        = (state == IDLE) && gate && !empty;
    assign busy       = !empty || (state == CLEAR);

    always_comb begin
        in_entry.blk = host_address[9:8];
        in_entry.idx = host_address[7:0];
        in_entry.dat = host_write_data;
    end

    vdp_sprite_meta_fifo #(
        .WIDTH     ($bits(entry_t)),
        .ADDR_BITS (FIFO_DEPTH_BITS)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (in_entry),
        .pop       (pop),
        .head      (head),
        .count     (fifo_level),
        .full      (full),
        .empty     (empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= IDLE;
            clr_idx           <= '0;
            meta_we           <= 1'b0;
            meta_address      <= '0;
            meta_write_data   <= '0;
            meta_block_select <= '0;
            overflow          <= 1'b0;
        end else begin
            meta_we <= 1'b0;
            if (host_write_en && full) begin
                overflow <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (pop) begin
                        if (head.blk == 2'd3) begin
                            state   <= CLEAR;
                            clr_idx <= '0;
                        end else begin
                            meta_we         <= 1'b1;
                            meta_address    <= head.idx;
                            meta_write_data <= head.dat;
                            case (head.blk)
                                2'd0:    meta_block_select <= 3'b001;
                                2'd1:    meta_block_select <= 3'b010;
                                default: meta_block_select <= 3'b100;
                            endcase
                        end
                    end
                end
                CLEAR: begin
                    // Closing vblank freezes clr_idx so the sweep resumes where it stopped.
                    if (gate) begin
                        meta_we           <= 1'b1;
                        meta_block_select <= 3'b010;
                        meta_address      <= clr_idx;
                        meta_write_data   <= {7'b0, HIDDEN_Y};
                        clr_idx           <= clr_idx + 1'b1;
                        if (clr_idx == 8'hFF) begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
